id_ex_pipe_reg: RTL



---
 rtl/id_ex_pipe_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with stall, flush, valid tracking
// and a saturating bubble counter for performance debug.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic             JumpE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic [CNT_W-1:0] BubbleCount
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } stage_t;

  stage_t           w_d;
  stage_t           r_e;
  logic [CNT_W-1:0] r_cnt;

  assign w_d = '{
    reg_write:  RegWriteD,
    mem_write:  MemWriteD,
    alu_src:    ALUSrcD,
    branch:     BranchD,
    jump:       JumpD,
    result_src: ResultSrcD,
    alu_ctrl:   ALUControlD,
    rd1:        RD1D,
    rd2:        RD2D,
    imm:        ImmExtD,
    pc:         PCD,
    pc4:        PCPlus4D,
    rs1:        Rs1D,
    rs2:        Rs2D,
    rd:         RdD,
    valid:      ValidD
  };

  // Flush zeroes data too so forwarding never matches a stale Rd/Rs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e   <= '0;
      r_cnt <= '0;
    end else if (FlushE) begin
      r_e <= '0;
      if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (!StallE) begin
      r_e <= w_d;
    end
  end

  assign RegWriteE   = r_e.reg_write;
  assign MemWriteE   = r_e.mem_write;
  assign ALUSrcE     = r_e.alu_src;
  assign BranchE     = r_e.branch;
  assign JumpE       = r_e.jump;
  assign ResultSrcE  = r_e.result_src;
  assign ALUControlE = r_e.alu_ctrl;
  assign RD1E        = r_e.rd1;
  assign RD2E        = r_e.rd2;
  assign ImmExtE     = r_e.imm;
  assign PCE         = r_e.pc;
  assign PCPlus4E    = r_e.pc4;
  assign Rs1E        = r_e.rs1;
  assign Rs2E        = r_e.rs2;
  assign RdE         = r_e.rd;
  assign ValidE      = r_e.valid;
  assign BubbleCount = r_cnt;

endmodule
